// File: rtl/encoder_position_gen.sv
// Encoder position source: ramps velocity toward a commanded target and
// integrates it into a shaft position that wraps once per revolution.
module encoder_position_gen #(
    parameter int          COUNTS_PER_REV = 1496,
    parameter int          FRAC_BITS      = 4,
    parameter logic [15:0] ACCEL_STEP     = 16'd16,
    parameter logic [15:0] MAX_VEL        = 16'd8000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_vel_cmd,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_sample_tick,
    output logic [15:0] o_position,
    output logic        o_pos_valid,
    output logic [15:0] o_velocity,
    output logic        o_busy
);

    localparam int AW = 16 + FRAC_BITS;
    localparam logic [AW:0] REV_Q = (AW + 1)'(COUNTS_PER_REV) << FRAC_BITS;
    localparam logic [16:0] REV_I = 17'(COUNTS_PER_REV);

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        RAMP_DOWN,
        CRUISE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [15:0]   vel_q, vel_d;
    logic [15:0]   tgt_q, tgt_d;
    logic          pv_q, pv_d;

    logic          accept;
    logic [AW:0]   sum;
    logic [AW:0]   sum_w;
    logic [16:0]   up_sum;
    logic [16:0]   dn_lim;
    logic [15:0]   vel_step;
    logic [15:0]   cmd_clamp;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            vel_q   <= '0;
            tgt_q   <= '0;
            pv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            vel_q   <= vel_d;
            tgt_q   <= tgt_d;
            pv_q    <= pv_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        vel_d     = vel_q;
        tgt_d     = tgt_q;
        pv_d      = 1'b0;
        accept    = i_cmd_valid && o_cmd_ready;
        cmd_clamp = (i_vel_cmd > MAX_VEL) ? MAX_VEL : i_vel_cmd;

        // one subtract is enough: velocity never exceeds one revolution/tick
        sum   = {1'b0, acc_q} + (AW + 1)'(vel_q);
        sum_w = (sum[AW:FRAC_BITS] >= REV_I) ? (sum - REV_Q) : sum;

        up_sum = {1'b0, vel_q} + {1'b0, ACCEL_STEP};
        dn_lim = {1'b0, tgt_q} + {1'b0, ACCEL_STEP};
        if (vel_q < tgt_q) begin
            vel_step = (up_sum >= {1'b0, tgt_q}) ? tgt_q : up_sum[15:0];
        end else if (vel_q > tgt_q) begin
            vel_step = ({1'b0, vel_q} <= dn_lim) ? tgt_q : vel_q - ACCEL_STEP;
        end else begin
            vel_step = vel_q;
        end

        if (i_sample_tick) begin
            acc_d = sum_w[AW-1:0];
            vel_d = vel_step;
            pv_d  = acc_d[AW-1:FRAC_BITS] != acc_q[AW-1:FRAC_BITS];
        end
        if (accept) begin
            tgt_d = cmd_clamp;
        end

        if (i_sample_tick || accept) begin
            if (vel_d < tgt_d) begin
                state_d = RAMP_UP;
            end else if (vel_d > tgt_d) begin
                state_d = RAMP_DOWN;
            end else if (vel_d == 16'd0) begin
                state_d = IDLE;
            end else begin
                state_d = CRUISE;
            end
        end
    end

    assign o_cmd_ready = (state_q == IDLE) || (state_q == CRUISE);
    assign o_busy      = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
    assign o_position  = acc_q[AW-1:FRAC_BITS];
    assign o_velocity  = vel_q;
    assign o_pos_valid = pv_q;

endmodule

// File: tb/tb_encoder_position_gen.sv
// Bench for encoder_position_gen: a reference model queues the expected
// outputs for each driven cycle; they are popped and compared after the edge.
module tb_encoder_position_gen;

    localparam int CPR = 1496;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] vel_cmd = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        tick = 1'b0;
    logic [15:0] position;
    logic        pos_valid;
    logic [15:0] velocity;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    int macc = 0;
    int mvel = 0;
    int mtgt = 0;

    typedef struct {
        int pos;
        int pv;
        int vel;
        int busy;
        int rdy;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    encoder_position_gen dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_vel_cmd    (vel_cmd),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_sample_tick(tick),
        .o_position   (position),
        .o_pos_valid  (pos_valid),
        .o_velocity   (velocity),
        .o_busy       (busy)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic tk, input logic vl,
                        input logic [15:0] cmd, input logic rs);
        exp_t e;
        int   nacc;
        bit   acc_ok;
        @(negedge clk);
        tick      = tk;
        cmd_valid = vl;
        vel_cmd   = cmd;
        rst       = rs;
        acc_ok    = vl && (mvel == mtgt);
        e.pv      = 0;
        if (rs) begin
            macc = 0;
            mvel = 0;
            mtgt = 0;
        end else begin
            if (tk) begin
                nacc = (macc + mvel) % (CPR * 16);
                e.pv = ((nacc / 16) != (macc / 16)) ? 1 : 0;
                macc = nacc;
                if (mvel < mtgt)
                    mvel = (mvel + 16 > mtgt) ? mtgt : mvel + 16;
                else if (mvel > mtgt)
                    mvel = (mvel - 16 < mtgt) ? mtgt : mvel - 16;
            end
            if (acc_ok)
                mtgt = (int'(cmd) > 8000) ? 8000 : int'(cmd);
        end
        e.pos  = macc / 16;
        e.vel  = mvel;
        e.busy = (mvel != mtgt) ? 1 : 0;
        e.rdy  = (mvel == mtgt) ? 1 : 0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("position", int'(position), e.pos);
        chk("pos_valid", int'(pos_valid), e.pv);
        chk("velocity", int'(velocity), e.vel);
        chk("busy", int'(busy), e.busy);
        chk("cmd_ready", int'(cmd_ready), e.rdy);
    endtask

    initial begin
        // reset, including a tick and command that must be ignored
        step(0, 0, 16'h0, 1);
        step(1, 1, 16'h0040, 1);
        chk("rst_pos", int'(position), 0);
        chk("rst_vel", int'(velocity), 0);
        chk("rst_ready", int'(cmd_ready), 1);

        // ramp to 4.0 counts/tick
        step(0, 1, 16'h0040, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 16'h0, 0);
        chk("ramp_vel", int'(velocity), 64);
        chk("ramp_pos", int'(position), 10);
        chk("ramp_busy", int'(busy), 0);

        // cruise up to the wrap point
        for (int i = 0; i < 371; i++) step(1, 0, 16'h0, 0);
        chk("pre_wrap_pos", int'(position), 1494);
        step(1, 0, 16'h0, 0);
        chk("wrap_pos", int'(position), 2);
        chk("wrap_pv", int'(pos_valid), 1);

        // stop from 4.0
        step(0, 1, 16'h0, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 16'h0, 0);
        step(0, 0, 16'h0, 0);
        chk("stop_vel", int'(velocity), 0);
        chk("stop_pos", int'(position), 12);

        // fractional velocity 0.5 from rest
        step(0, 0, 16'h0, 1);
        step(0, 1, 16'h0008, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 16'h0, 0);
        chk("frac_vel", int'(velocity), 8);
        chk("frac_pos", int'(position), 3);

        // held 0xFFFF only taken once cruising; tick+accept uses old target
        step(0, 1, 16'h0040, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 16'hFFFF, 0);
        chk("clamp_vel", int'(velocity), 80);
        chk("clamp_busy", int'(busy), 1);
        for (int i = 0; i < 3; i++) step(1, 0, 16'h0, 0);

        // reset mid-ramp with no tick
        step(0, 0, 16'h0, 1);
        step(0, 1, 16'h0040, 0);
        step(1, 0, 16'h0, 0);
        step(1, 0, 16'h0, 0);
        chk("mid_vel", int'(velocity), 32);
        step(0, 0, 16'h0, 1);
        chk("mid_rst_vel", int'(velocity), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ready", int'(cmd_ready), 1);

        // ramp down from 4.0 and freeze
        step(0, 1, 16'h0040, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 16'h0, 0);
        step(0, 1, 16'h0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 16'h0, 0);
        chk("down_vel", int'(velocity), 0);
        for (int i = 0; i < 3; i++) step(1, 0, 16'h0, 0);
        chk("frozen_pv", int'(pos_valid), 0);

        tick      = 1'b0;
        cmd_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
